// File: rtl/controlador_barramento_if.sv
// Cache- and memory-side signals of the MSI snooping bus controller.
// master = controller view, slave = caches + memory view.
interface controlador_barramento_if #(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
);
    logic [2*NUM_CACHES-1:0]      pedidoMsg;
    logic [ADDR_W*NUM_CACHES-1:0] pedidoEnd;
    logic [2*NUM_CACHES-1:0]      entradaBarramento;
    logic [ADDR_W-1:0]            barramentoEnd;
    logic [NUM_CACHES-1:0]        writeBack;
    logic [NUM_CACHES-1:0]        abortAccessMemory;
    logic [DATA_W*NUM_CACHES-1:0] dadoWB;
    logic [NUM_CACHES-1:0]        concluido;
    logic [DATA_W-1:0]            dadoResposta;
    logic [ADDR_W-1:0]            memEnd;
    logic                         memLe;
    logic                         memEscreve;
    logic [DATA_W-1:0]            memDadoEscrita;
    logic [DATA_W-1:0]            memDadoLido;
    logic                         memPronto;

    modport master (
        input  pedidoMsg,
        input  pedidoEnd,
        output entradaBarramento,
        output barramentoEnd,
        input  writeBack,
        input  abortAccessMemory,
        input  dadoWB,
        output concluido,
        output dadoResposta,
        output memEnd,
        output memLe,
        output memEscreve,
        output memDadoEscrita,
        input  memDadoLido,
        input  memPronto
    );

    modport slave (
        output pedidoMsg,
        output pedidoEnd,
        input  entradaBarramento,
        input  barramentoEnd,
        output writeBack,
        output abortAccessMemory,
        output dadoWB,
        input  concluido,
        input  dadoResposta,
        input  memEnd,
        input  memLe,
        input  memEscreve,
        input  memDadoEscrita,
        output memDadoLido,
        input  memPronto
    );
endinterface

// File: rtl/controlador_barramento.sv
// Shared-bus controller for MSI snooping: round-robin grant,
// broadcast, snoop collection, memory read or owner write-back.
module controlador_barramento #(
    parameter int NUM_CACHES  = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    controlador_barramento_if.master bus,
    output logic                     ocupado,
    output logic                     conflito,
    output logic                     erroMem
);
    localparam int IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        OCIOSO,
        DIFUSAO,
        ESCUTA,
        ESCRITA_MEM,
        LEITURA_MEM,
        CONCLUI
    } estado_t;

    estado_t               estado;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      req;
    logic [1:0]            msg;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     resp;
    logic [CNT_W-1:0]      cnt;

    logic                  achou;
    logic [IDX_W-1:0]      vencedor;
    logic [1:0]            msg_v;
    logic [ADDR_W-1:0]     end_v;
    logic [NUM_CACHES-1:0] mask_v;

    logic [NUM_CACHES-1:0] mask_req;
    logic [NUM_CACHES-1:0] donos;
    logic                  multi;
    logic [DATA_W-1:0]     dado_dono;
    logic [IDX_W-1:0]      ptr_prox;

    // Message on every slice except the masked (requester) one.
    function automatic logic [2*NUM_CACHES-1:0] difusao(
        input logic [NUM_CACHES-1:0] m_req,
        input logic [1:0]            m
    );
        logic [2*NUM_CACHES-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (!m_req[i]) v[2*i +: 2] = m;
        end
        return v;
    endfunction

    // Round-robin search for the first requester from ptr.
    always_comb begin : arb
        int j;
        j        = 0;
        achou    = 1'b0;
        vencedor = '0;
        msg_v    = 2'b11;
        end_v    = '0;
        for (int k = 0; k < NUM_CACHES; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CACHES) j = j - NUM_CACHES;
            if (!achou && bus.pedidoMsg[2*j +: 2] != 2'b11) begin
                achou    = 1'b1;
                vencedor = IDX_W'(j);
                msg_v    = bus.pedidoMsg[2*j +: 2];
                end_v    = bus.pedidoEnd[ADDR_W*j +: ADDR_W];
            end
        end
        mask_v = NUM_CACHES'(1) << vencedor;
    end

    // Snoop decode: lowest-index owner among non-requesters.
    always_comb begin
        mask_req  = NUM_CACHES'(1) << req;
        donos     = bus.abortAccessMemory & ~mask_req;
        multi     = |(donos & (donos - 1'b1));
        dado_dono = '0;
        for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            if (donos[i]) dado_dono = bus.dadoWB[DATA_W*i +: DATA_W];
        end
        if (req == IDX_W'(NUM_CACHES - 1)) ptr_prox = '0;
        else ptr_prox = req + 1'b1;
    end

    // Transaction FSM with registered bus and memory outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado                <= OCIOSO;
            ptr                   <= '0;
            req                   <= '0;
            msg                   <= 2'b11;
            addr                  <= '0;
            resp                  <= '0;
            cnt                   <= '0;
            bus.entradaBarramento <= '1;
            bus.barramentoEnd     <= '0;
            bus.concluido         <= '0;
            bus.dadoResposta      <= '0;
            bus.memEnd            <= '0;
            bus.memLe             <= 1'b0;
            bus.memEscreve        <= 1'b0;
            bus.memDadoEscrita    <= '0;
            ocupado               <= 1'b0;
            conflito              <= 1'b0;
            erroMem               <= 1'b0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (achou) begin
                        req  <= vencedor;
                        msg  <= msg_v;
                        addr <= end_v;
                        bus.entradaBarramento <=
                            difusao(mask_v, msg_v);
                        bus.barramentoEnd <= end_v;
                        ocupado <= 1'b1;
                        estado  <= DIFUSAO;
                    end
                end
                DIFUSAO: begin
                    estado <= ESCUTA;
                end
                ESCUTA: begin
                    bus.entradaBarramento <= '1;
                    bus.barramentoEnd     <= '0;
                    cnt                   <= '0;
                    if (msg == 2'b00) begin
                        bus.concluido    <= mask_req;
                        bus.dadoResposta <= '0;
                        estado           <= CONCLUI;
                    end else if (|donos) begin
                        if (multi) conflito <= 1'b1;
                        bus.memEscreve     <= 1'b1;
                        bus.memEnd         <= addr;
                        bus.memDadoEscrita <= dado_dono;
                        resp               <= dado_dono;
                        estado             <= ESCRITA_MEM;
                    end else begin
                        bus.memLe  <= 1'b1;
                        bus.memEnd <= addr;
                        estado     <= LEITURA_MEM;
                    end
                end
                ESCRITA_MEM, LEITURA_MEM: begin
                    if (bus.memPronto) begin
                        bus.memLe          <= 1'b0;
                        bus.memEscreve     <= 1'b0;
                        bus.memEnd         <= '0;
                        bus.memDadoEscrita <= '0;
                        bus.concluido      <= mask_req;
                        if (estado == LEITURA_MEM)
                            bus.dadoResposta <= bus.memDadoLido;
                        else
                            bus.dadoResposta <= resp;
                        estado <= CONCLUI;
                    end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        bus.memLe          <= 1'b0;
                        bus.memEscreve     <= 1'b0;
                        bus.memEnd         <= '0;
                        bus.memDadoEscrita <= '0;
                        bus.concluido      <= mask_req;
                        bus.dadoResposta   <= '0;
                        erroMem            <= 1'b1;
                        estado             <= CONCLUI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONCLUI: begin
                    bus.concluido    <= '0;
                    bus.dadoResposta <= '0;
                    ptr              <= ptr_prox;
                    ocupado          <= 1'b0;
                    estado           <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_barramento.sv
// Directed bench for controlador_barramento: vector table of
// single transactions plus timeout, reset and round-robin runs.
module tb_controlador_barramento;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int T  = 255;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ocupado, conflito, erroMem;

    int n_chk = 0;
    int n_fail = 0;

    controlador_barramento_if #(
        .NUM_CACHES(N), .ADDR_W(AW), .DATA_W(DW)
    ) bi ();

    controlador_barramento #(
        .NUM_CACHES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_TIMEOUT(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bi),
        .ocupado(ocupado),
        .conflito(conflito),
        .erroMem(erroMem)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         c;
        logic [1:0] m;
        logic [7:0] a;
        logic [3:0] ab;
        logic [3:0] wbk;
        logic [31:0] dwb;
        int         espera;
        logic [7:0] lido;
        int         e_fim;
        logic [3:0] e_conc;
        logic [7:0] e_resp;
        int         e_le;
        int         e_esc;
        logic [7:0] e_wd;
    } vec_t;

    typedef struct {
        int         fim;
        int         nLe;
        int         nEsc;
        int         nOcup;
        int         bcast_err;
        int         overlap;
        logic [3:0] conc;
        logic [7:0] resp;
        logic [7:0] wdata;
        logic       erro_pre;
        logic       erro;
        logic       confl;
        logic       strobe_fim;
    } res_t;

    task automatic chk(input string nome,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    task automatic transacao(input int c, input logic [1:0] m,
                             input logic [7:0] a,
                             input logic [3:0] ab,
                             input logic [3:0] wbk,
                             input logic [31:0] dwb,
                             input int espera,
                             input logic [7:0] lido,
                             input int limite,
                             output res_t r);
        int s;
        logic [7:0] bexp;
        r = '{fim: -1, default: 0};
        s = 0;
        for (int i = 0; i < N; i++)
            bexp[2*i +: 2] = (i == c) ? 2'b11 : m;
        @(negedge clock);
        bi.pedidoMsg[2*c +: 2] = m;
        bi.pedidoEnd[8*c +: 8] = a;
        bi.abortAccessMemory = ab;
        bi.writeBack = wbk;
        bi.dadoWB = dwb;
        bi.memDadoLido = lido;
        bi.memPronto = 1'b0;
        @(posedge clock);
        for (int n = 1; n <= limite && r.fim < 0; n++) begin
            @(negedge clock);
            if (n == 1 || n == 2) begin
                if (bi.entradaBarramento !== bexp ||
                    bi.barramentoEnd !== a) r.bcast_err++;
            end else if (bi.entradaBarramento !== 8'hFF) begin
                r.bcast_err++;
            end
            if (bi.memLe) r.nLe++;
            if (bi.memEscreve) begin
                r.nEsc++;
                r.wdata = bi.memDadoEscrita;
            end
            if (bi.memLe && bi.memEscreve) r.overlap++;
            if (ocupado) r.nOcup++;
            if (|bi.concluido) begin
                r.fim = n;
                r.conc = bi.concluido;
                r.resp = bi.dadoResposta;
                r.strobe_fim = bi.memLe | bi.memEscreve;
                r.erro = erroMem;
                r.confl = conflito;
            end else begin
                r.erro_pre = erroMem;
            end
            if (bi.memLe || bi.memEscreve) begin
                s++;
                bi.memPronto = (espera >= 0 && s == espera + 1);
            end
        end
        bi.pedidoMsg[2*c +: 2] = 2'b11;
        bi.abortAccessMemory = '0;
        bi.writeBack = '0;
        bi.memPronto = 1'b0;
    endtask

    vec_t tab [7];
    res_t r;
    logic [3:0] rr_exp [4];
    logic [3:0] rr_seq [4];
    int rr_when [4];
    int got;
    int npulsos;

    initial begin
        tab[0] = '{2, 2'b00, 8'h3C, 4'b0000, 4'b0000, 32'h0,
                   0, 8'h00, 3, 4'b0100, 8'h00, 0, 0, 8'h00};
        tab[1] = '{0, 2'b01, 8'h10, 4'b0000, 4'b0000, 32'h0,
                   2, 8'hA5, 6, 4'b0001, 8'hA5, 3, 0, 8'h00};
        tab[2] = '{1, 2'b10, 8'h22, 4'b1000, 4'b1000, 32'h5A112233,
                   1, 8'hEE, 5, 4'b0010, 8'h5A, 0, 2, 8'h5A};
        tab[3] = '{3, 2'b01, 8'h7F, 4'b0000, 4'b0001, 32'h00000099,
                   0, 8'h77, 4, 4'b1000, 8'h77, 1, 0, 8'h00};
        tab[4] = '{2, 2'b01, 8'h91, 4'b0100, 4'b0100, 32'h00440000,
                   1, 8'hC3, 5, 4'b0100, 8'hC3, 2, 0, 8'h00};
        tab[5] = '{1, 2'b00, 8'h80, 4'b0001, 4'b0001, 32'h00000011,
                   0, 8'h00, 3, 4'b0010, 8'h00, 0, 0, 8'h00};
        tab[6] = '{0, 2'b10, 8'hF0, 4'b0000, 4'b0000, 32'h0,
                   3, 8'h3C, 7, 4'b0001, 8'h3C, 4, 0, 8'h00};
        rr_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

        bi.pedidoMsg = '1;
        bi.pedidoEnd = '0;
        bi.writeBack = '0;
        bi.abortAccessMemory = '0;
        bi.dadoWB = '0;
        bi.memDadoLido = '0;
        bi.memPronto = 1'b0;

        #1 reset = 1'b0;
        #2;
        chk("rst_entrada", bi.entradaBarramento, 8'hFF);
        chk("rst_concluido", bi.concluido, 4'b0000);
        chk("rst_strobes", {bi.memLe, bi.memEscreve}, 2'b00);
        chk("rst_flags", {ocupado, conflito, erroMem}, 3'b000);
        chk("rst_resposta", bi.dadoResposta, 8'h00);
        @(negedge clock);
        #2 reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            transacao(tab[v].c, tab[v].m, tab[v].a, tab[v].ab,
                      tab[v].wbk, tab[v].dwb, tab[v].espera,
                      tab[v].lido, 40, r);
            chk($sformatf("v%0d_fim", v), r.fim, tab[v].e_fim);
            chk($sformatf("v%0d_conc", v), r.conc, tab[v].e_conc);
            chk($sformatf("v%0d_resp", v), r.resp, tab[v].e_resp);
            chk($sformatf("v%0d_nLe", v), r.nLe, tab[v].e_le);
            chk($sformatf("v%0d_nEsc", v), r.nEsc, tab[v].e_esc);
            chk($sformatf("v%0d_wdata", v), r.wdata, tab[v].e_wd);
            chk($sformatf("v%0d_bcast", v), r.bcast_err, 0);
            chk($sformatf("v%0d_overlap", v), r.overlap, 0);
            chk($sformatf("v%0d_ocupado", v), r.nOcup, tab[v].e_fim);
            chk($sformatf("v%0d_strobe_fim", v), r.strobe_fim, 1'b0);
            chk($sformatf("v%0d_flags", v), {r.confl, r.erro}, 2'b00);
        end

        // Two owners (1 and 2), memory never answers.
        transacao(0, 2'b01, 8'h44, 4'b0110, 4'b0110, 32'h33996600,
                  -1, 8'hBB, 400, r);
        chk("to_fim", r.fim, 3 + T);
        chk("to_conc", r.conc, 4'b0001);
        chk("to_resp", r.resp, 8'h00);
        chk("to_nEsc", r.nEsc, T);
        chk("to_nLe", r.nLe, 0);
        chk("to_owner_data", r.wdata, 8'h66);
        chk("to_conflito", r.confl, 1'b1);
        chk("to_erro_pre", r.erro_pre, 1'b0);
        chk("to_erro", r.erro, 1'b1);
        chk("to_strobe_fim", r.strobe_fim, 1'b0);

        // Reset in the middle of a memory read.
        @(negedge clock);
        bi.pedidoMsg[7:6] = 2'b01;
        bi.pedidoEnd[31:24] = 8'h55;
        @(posedge clock);
        repeat (4) @(negedge clock);
        chk("mid_memLe", bi.memLe, 1'b1);
        #2 reset = 1'b0;
        bi.pedidoMsg = '1;
        #1;
        chk("arst_memLe", bi.memLe, 1'b0);
        chk("arst_entrada", bi.entradaBarramento, 8'hFF);
        chk("arst_flags", {ocupado, conflito, erroMem}, 3'b000);
        #4 reset = 1'b1;
        npulsos = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (|bi.concluido) npulsos++;
        end
        chk("arst_no_concluido", npulsos, 0);

        // Round robin between caches 0 and 1, requests held.
        @(negedge clock);
        bi.pedidoEnd[7:0] = 8'h01;
        bi.pedidoEnd[15:8] = 8'h02;
        bi.pedidoMsg[1:0] = 2'b00;
        bi.pedidoMsg[3:2] = 2'b00;
        got = 0;
        for (int n = 1; n <= 40 && got < 4; n++) begin
            @(negedge clock);
            if (|bi.concluido) begin
                rr_seq[got] = bi.concluido;
                rr_when[got] = n;
                got++;
            end
        end
        bi.pedidoMsg = '1;
        chk("rr_count", got, 4);
        if (got == 4) begin
            chk("rr_first_at", rr_when[0], 3);
            for (int i = 0; i < 4; i++)
                chk($sformatf("rr_grant%0d", i), rr_seq[i], rr_exp[i]);
            for (int i = 1; i < 4; i++)
                chk($sformatf("rr_gap%0d", i),
                    rr_when[i] - rr_when[i-1], 4);
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/controlador_barramento.md
# controlador_barramento

Shared-bus controller for the MSI snooping coherence protocol. It sits between N per-line cache coherence controllers and main memory. It arbitrates among pending bus requests (invalidar, readMiss, writeMiss) and broadcasts the granted message to every other cache. It then collects their snoop responses (writeBack / abortAccessMemory) and either runs the memory read or performs the owner's write-back and forwards the owner's data, returning completion to the requester.

## Interface
- NUM_CACHES, 4, number of attached caches (2..8)
- ADDR_W, 8, block address width
- DATA_W, 8, block data width
- MEM_TIMEOUT, 255, max cycles waiting on memPronto before error
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- pedidoMsg  in  2*NUM_CACHES  per-cache message request, slice i = cache i; 11 = none
- pedidoEnd  in  ADDR_W*NUM_CACHES  per-cache block address
- entradaBarramento  out  2*NUM_CACHES  per-cache snooped message; 11 = nothing
- barramentoEnd  out  ADDR_W  address of the broadcast message
- writeBack  in  NUM_CACHES  snoop response: cache i writes back its block
- abortAccessMemory  in  NUM_CACHES  snoop response: cache i owns the block and supplies the data
- dadoWB  in  DATA_W*NUM_CACHES  per-cache write-back data
- concluido  out  NUM_CACHES  one-cycle completion pulse to the requester
- dadoResposta  out  DATA_W  block data for the requester, valid while concluido is high
- memEnd  out  ADDR_W  memory address
- memLe  out  1  memory read strobe, level
- memEscreve  out  1  memory write strobe, level
- memDadoEscrita  out  DATA_W  memory write data
- memDadoLido  in  DATA_W  memory read data
- memPronto  in  1  memory completes the current access
- ocupado  out  1  high in any state other than OCIOSO
- conflito  out  1  sticky: more than one owner in a single snoop
- erroMem  out  1  sticky: memory timeout

## Operation
- Message encoding: 00 invalidar, 01 readMiss, 10 writeMiss, 11 none.
- Request rules:
  - Cache i is requesting while its pedidoMsg slice is not 11.
  - A requester holds the message and address stable until its concluido pulse.
- Arbitration:
  - Round-robin. The search starts at (last grant + 1) mod NUM_CACHES; the pointer resets to 0.
  - A grant latches the requester index, message and address.
- States:
  - OCIOSO: if any request, grant and go to DIFUSAO.
  - DIFUSAO: drive the latched message on every entradaBarramento slice except the requester's (which stays 11). Drive barramentoEnd. Go to ESCUTA.
  - ESCUTA: keep the broadcast driven and sample writeBack / abortAccessMemory from non-requesters. The requester's own response bits are ignored.
    - invalidar: go to CONCLUI.
    - Any abortAccessMemory set: the owner is the lowest such index. If more than one is set, also set conflito. Go to ESCRITA_MEM.
    - Otherwise: go to LEITURA_MEM.
  - ESCRITA_MEM: memEscreve=1, memEnd = latched address, memDadoEscrita = owner's dadoWB. The owner data is also latched as the response. On memPronto go to CONCLUI; memory is not read.
  - LEITURA_MEM: memLe=1, memEnd = latched address. On memPronto latch memDadoLido as the response and go to CONCLUI.
  - CONCLUI: concluido[req]=1 and dadoResposta = latched response (00..0 for invalidar). Advance the round-robin pointer and go to OCIOSO.
- Outside DIFUSAO/ESCUTA, every entradaBarramento slice is 11.
- Timeout: in either memory state, a wait counter reaching MEM_TIMEOUT sets erroMem and goes to CONCLUI with response 0.
- writeBack without abortAccessMemory is ignored by the controller.

## Timing
- Reset (asynchronous, reset=0):
  - State OCIOSO; entradaBarramento all 11.
  - All other outputs 0, including concluido, memLe, memEscreve, ocupado, conflito, erroMem and dadoResposta.
  - Pointer 0, counter 0.
  - Reset mid-transaction aborts it with no concluido pulse.
- Request at edge k (state OCIOSO):
  - DIFUSAO in cycle k+1, ESCUTA in k+2.
  - invalidar: concluido in k+3.
  - Memory access: strobe from k+3. If memPronto is seen at edge m, concluido is in cycle m+1.
- Zero-wait memory (memPronto already high in k+3): concluido in k+4.
- Back-to-back: a new grant is possible at the first edge after CONCLUI, so the minimum spacing is 4 cycles for invalidar.
- memLe and memEscreve are never high together and drop in the cycle concluido rises.

## Test plan
- Invalidar, single cache: cache 2 requests 00 at address 0x3C → caches 0, 1, 3 see 00 and barramentoEnd=0x3C for 2 cycles; slice 2 stays 11; concluido=0100 exactly 3 cycles after the request; memLe=memEscreve=0.
- ReadMiss from memory: cache 0 requests 01 at 0x10, no snoop responses, memPronto after 2 wait cycles with memDadoLido=0xA5 → memLe high 3 cycles, dadoResposta=0xA5 with concluido=0001.
- WriteMiss with owner: cache 1 requests 10; cache 3 asserts writeBack+abortAccessMemory with dadoWB=0x5A → memEscreve=1, memDadoEscrita=0x5A; memLe never high; dadoResposta=0x5A; conflito=0.
- Round-robin fairness: caches 0 and 1 request simultaneously and re-request immediately after completion → grants alternate 0,1,0,1; neither is served twice in a row.
- Double owner plus timeout: caches 1 and 2 both abort, memPronto held low → owner is cache 1, conflito=1, erroMem=1 after MEM_TIMEOUT cycles, concluido still pulses with response 0.
- Async reset mid-LEITURA_MEM: assert reset for one half-cycle → memLe=0 and entradaBarramento=all 11 immediately; no concluido; the next request is granted starting at cache 0.
